// File: rtl/subservient_gpio_bank.sv
// rtl/subservient_gpio_bank.sv - multi-bit Wishbone GPIO bank with optional edge IRQs
// Optional edge-detect interrupt logic is built when SUBSERVIENT_GPIO_IRQ_EN is defined.
module subservient_gpio_bank #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst_n,
  input  logic [2:0]       i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic             i_wb_we,
  input  logic             i_wb_stb,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack,
  input  logic [WIDTH-1:0] i_gpio,
  output logic [WIDTH-1:0] o_gpio,
  output logic [WIDTH-1:0] o_gpio_oe,
  output logic             o_irq
);

  logic             r_ack;
  logic [31:0]      r_rdt;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];

  logic             w_acc;
  logic             w_wr;
  logic [WIDTH-1:0] w_in;
  logic [WIDTH-1:0] w_wdat;
  logic [WIDTH-1:0] w_rd_reg;
  logic [31:0]      w_rdt;
  logic             w_unused;

  // A strobe is only taken while no ack is outstanding, giving one transfer per ack.
  assign w_acc    = i_wb_stb & ~r_ack;
  assign w_wr     = w_acc & i_wb_we;
  assign w_in     = r_sync[SYNC_STAGES-1];
  assign w_wdat   = i_wb_dat[WIDTH-1:0];
  assign w_unused = &{1'b0, i_wb_dat};

`ifdef SUBSERVIENT_GPIO_IRQ_EN
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_pol;
  logic [WIDTH-1:0] r_status;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;

  assign w_edge = (r_pol & r_prev & ~w_in) | (~r_pol & ~r_prev & w_in);
  assign w_clr  = (w_wr && i_wb_adr == 3'd5) ? w_wdat : '0;
  assign o_irq  = |r_status;

  // Set is ORed in after the clear so a coincident edge keeps the bit pending.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_prev   <= '0;
      r_mask   <= '0;
      r_pol    <= '0;
      r_status <= '0;
    end else begin
      r_prev   <= w_in;
      r_status <= (r_status & ~w_clr) | (w_edge & r_mask);
      if (w_wr && i_wb_adr == 3'd3) r_mask <= w_wdat;
      if (w_wr && i_wb_adr == 3'd4) r_pol  <= w_wdat;
    end
  end
`else
  assign o_irq = 1'b0;
`endif

  always_comb begin
    w_rd_reg = '0;
    case (i_wb_adr)
      3'd0:    w_rd_reg = r_out;
      3'd1:    w_rd_reg = r_dir;
      3'd2:    w_rd_reg = w_in;
`ifdef SUBSERVIENT_GPIO_IRQ_EN
      3'd3:    w_rd_reg = r_mask;
      3'd4:    w_rd_reg = r_pol;
      3'd5:    w_rd_reg = r_status;
`endif
      default: w_rd_reg = '0;
    endcase
  end

  always_comb begin
    w_rdt             = '0;
    w_rdt[WIDTH-1:0]  = w_rd_reg;
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_ack <= 1'b0;
      r_rdt <= '0;
      r_out <= '0;
      r_dir <= '0;
    end else begin
      r_ack <= w_acc;
      if (w_acc) r_rdt <= w_rdt;
      if (w_wr && i_wb_adr == 3'd0) r_out <= w_wdat;
      if (w_wr && i_wb_adr == 3'd1) r_dir <= w_wdat;
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_gpio;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_wb_ack  = r_ack;
  assign o_wb_rdt  = r_rdt;
  assign o_gpio    = r_out;
  assign o_gpio_oe = r_dir;

endmodule

// File: tb/tb_subservient_gpio_bank.sv
// tb/tb_subservient_gpio_bank.sv - self-checking bench for subservient_gpio_bank
// IRQ sequences run when SUBSERVIENT_GPIO_IRQ_EN is defined, unmapped checks otherwise.
module tb_subservient_gpio_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  adr;
  logic [31:0] dat;
  logic        we;
  logic        stb;
  logic [31:0] rdt;
  logic        ack;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic        irq;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [31:0] dat;
    logic [31:0] exp_rdt;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
  } vec_t;

  vec_t vecs[11];

  subservient_gpio_bank #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .i_wb_clk  (clk),
    .i_wb_rst_n(rst_n),
    .i_wb_adr  (adr),
    .i_wb_dat  (dat),
    .i_wb_we   (we),
    .i_wb_stb  (stb),
    .o_wb_rdt  (rdt),
    .o_wb_ack  (ack),
    .i_gpio    (gpio_in),
    .o_gpio    (gpio_out),
    .o_gpio_oe (gpio_oe),
    .o_irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard: every ack pops one expected read-data word.
  always @(negedge clk) begin
    if (rst_n && ack) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ack: got ack with empty scoreboard at %0t", $time);
      end else begin
        check("rdt", rdt, exp_q.pop_front());
      end
    end
  end

  task automatic xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rdt);
    @(negedge clk);
    we = w; adr = a; dat = d; stb = 1'b1;
    exp_q.push_back(exp_rdt);
    @(negedge clk);
    check("ack_latency", {31'd0, ack}, 32'd1);
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [5:0] ack_seen;
    int         n_acks;

    vecs[0]  = '{1'b1, 3'd1, 32'h0000_000F, 32'h0000_0000, 8'hA5, 8'h0F};
    vecs[1]  = '{1'b0, 3'd1, 32'h0,         32'h0000_000F, 8'hA5, 8'h0F};
    vecs[2]  = '{1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0000_00A5, 8'hFF, 8'h0F};
    vecs[3]  = '{1'b0, 3'd0, 32'h0,         32'h0000_00FF, 8'hFF, 8'h0F};
    vecs[4]  = '{1'b0, 3'd6, 32'h0,         32'h0000_0000, 8'hFF, 8'h0F};
    vecs[5]  = '{1'b1, 3'd7, 32'h0000_0012, 32'h0000_0000, 8'hFF, 8'h0F};
    vecs[6]  = '{1'b0, 3'd7, 32'h0,         32'h0000_0000, 8'hFF, 8'h0F};
    vecs[7]  = '{1'b1, 3'd1, 32'hFFFF_FF00, 32'h0000_000F, 8'hFF, 8'h00};
    vecs[8]  = '{1'b0, 3'd1, 32'h0,         32'h0000_0000, 8'hFF, 8'h00};
    vecs[9]  = '{1'b1, 3'd1, 32'h0000_005A, 32'h0000_0000, 8'hFF, 8'h5A};
    vecs[10] = '{1'b0, 3'd1, 32'h0,         32'h0000_005A, 8'hFF, 8'h5A};

    // Reset held with a strobe pending: nothing may respond.
    rst_n = 1'b0; stb = 1'b1; we = 1'b1; adr = 3'd0; dat = 32'hFF; gpio_in = 8'h00;
    idle(3);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_rdt", rdt, 32'd0);
    check("rst_gpio", {24'd0, gpio_out}, 32'd0);
    check("rst_oe", {24'd0, gpio_oe}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    xfer(1'b1, 3'd0, 32'h0000_00A5, 32'h0);
    check("out_a5", {24'd0, gpio_out}, 32'hA5);

    foreach (vecs[i]) begin
      xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].exp_rdt);
      check($sformatf("vec%0d_out", i), {24'd0, gpio_out}, {24'd0, vecs[i].exp_out});
      check($sformatf("vec%0d_oe", i), {24'd0, gpio_oe}, {24'd0, vecs[i].exp_oe});
    end

    // Synchroniser depth: first read lands before the second stage has the new value.
    gpio_in = 8'h3C;
    xfer(1'b0, 3'd2, 32'h0, 32'h0000_0000);
    xfer(1'b0, 3'd2, 32'h0, 32'h0000_003C);
    xfer(1'b1, 3'd2, 32'hFF, 32'h0000_003C);
    xfer(1'b0, 3'd2, 32'h0, 32'h0000_003C);

    // Held strobe: ack alternates, one transfer per ack.
    @(negedge clk);
    repeat (3) exp_q.push_back(32'h0000_003C);
    n_acks = 0;
    adr = 3'd2; we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      ack_seen[c] = ack;
      if (ack) n_acks++;
      if (c == 0) stb = 1'b1;
    end
    stb = 1'b0;
    check("stb_held_pattern", {26'd0, ack_seen}, 32'b101010);
    check("stb_held_acks", n_acks, 3);
    idle(2);

`ifdef SUBSERVIENT_GPIO_IRQ_EN
    xfer(1'b1, 3'd3, 32'h01, 32'h0);
    xfer(1'b1, 3'd4, 32'h00, 32'h0);
    gpio_in = 8'h3D;
    idle(5);
    check("irq_rise", {31'd0, irq}, 32'd1);
    xfer(1'b0, 3'd5, 32'h0, 32'h01);
    gpio_in = 8'h3F;
    idle(5);
    xfer(1'b0, 3'd5, 32'h0, 32'h01);
    xfer(1'b1, 3'd5, 32'h01, 32'h01);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    xfer(1'b0, 3'd5, 32'h0, 32'h00);

    // Falling polarity; second fall lands on the same edge as the W1C.
    xfer(1'b1, 3'd4, 32'h01, 32'h00);
    gpio_in = 8'h3E;
    idle(5);
    check("irq_fall", {31'd0, irq}, 32'd1);
    gpio_in = 8'h3F;
    idle(5);
    gpio_in = 8'h3E;
    @(negedge clk);
    xfer(1'b1, 3'd5, 32'h01, 32'h01);
    check("set_wins_irq", {31'd0, irq}, 32'd1);
    xfer(1'b0, 3'd5, 32'h0, 32'h01);
    xfer(1'b1, 3'd3, 32'h00, 32'h01);
    check("mask_keeps_status", {31'd0, irq}, 32'd1);
    xfer(1'b1, 3'd5, 32'hFF, 32'h01);
    check("final_clear", {31'd0, irq}, 32'd0);
`else
    for (int a = 3; a <= 5; a++) xfer(1'b1, a[2:0], 32'hFF, 32'h0);
    gpio_in = 8'hC3;
    idle(5);
    gpio_in = 8'h3C;
    idle(5);
    for (int a = 3; a <= 5; a++) xfer(1'b0, a[2:0], 32'h0, 32'h0);
    check("no_irq", {31'd0, irq}, 32'd0);
`endif

    // Reset during a pending strobe: abandoned, state cleared asynchronously.
    @(negedge clk);
    we = 1'b1; adr = 3'd0; dat = 32'h77; stb = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("async_rst_gpio", {24'd0, gpio_out}, 32'd0);
    check("async_rst_oe", {24'd0, gpio_oe}, 32'd0);
    @(negedge clk);
    check("async_rst_ack", {31'd0, ack}, 32'd0);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b1, 3'd0, 32'h33, 32'h0);
    check("post_rst_out", {24'd0, gpio_out}, 32'h33);
    xfer(1'b0, 3'd1, 32'h0, 32'h0);

    idle(2);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/subservient_gpio_bank.md
Name: subservient_gpio_bank

Overview:
- Parametrised multi-bit GPIO peripheral for the subservient SoC; replaces the single-bit GPIO on the Wishbone peripheral bus.
- Provides per-bit output data, output-enable and synchronised input read-back.
- Optionally provides per-bit edge-detect interrupts with a single combined IRQ line to the core.

Parameters:
- WIDTH, 8: number of GPIO pins, 1..32.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.

Ports:
- i_wb_clk  in  1  bus/system clock.
- i_wb_rst_n  in  1  asynchronous active-low reset.
- i_wb_adr  in  3  word address within block.
- i_wb_dat  in  32  write data.
- i_wb_we  in  1  write enable.
- i_wb_stb  in  1  strobe (cycle qualifier).
- o_wb_rdt  out  32  read data.
- o_wb_ack  out  1  transfer acknowledge.
- i_gpio  in  WIDTH  raw pin inputs, asynchronous to i_wb_clk.
- o_gpio  out  WIDTH  output data.
- o_gpio_oe  out  WIDTH  output enable, 1 = drive.
- o_irq  out  1  level interrupt, OR of pending status bits.

Behaviour:
- Reset is asynchronous and active-low (i_wb_rst_n = 0). All state clears immediately: o_wb_ack = 0, o_wb_rdt = 0, o_gpio = 0, o_gpio_oe = 0, synchroniser and edge history = 0, IRQ mask/polarity/status = 0, o_irq = 0.
- Register map (by i_wb_adr):
  - 0 OUT: R/W.
  - 1 DIR: R/W, drives o_gpio_oe.
  - 2 IN: RO, synchronised pins; writes ignored.
  - 3 IRQ_MASK: R/W.
  - 4 IRQ_POL: R/W; 0 = rising, 1 = falling.
  - 5 IRQ_STATUS: write-1-to-clear.
  - 6, 7: read 0, writes ignored.
- Bits [31:WIDTH] read 0 in every register; written values in those bits are discarded.
- Handshake: a transfer is accepted on a rising edge where i_wb_stb = 1 and o_wb_ack = 0. At that edge:
  - o_wb_ack rises for exactly one cycle.
  - o_wb_rdt captures the addressed register's value before any write in the same cycle.
  - The write, if any, takes effect.
- Consequences of the handshake rule:
  - Ack latency is one cycle.
  - A strobe held high produces ack on alternating cycles, with one transfer per ack.
  - o_wb_rdt holds its value between transfers.
- Input path: i_gpio passes through a SYNC_STAGES-deep flop chain. IN reflects a stable pin change after SYNC_STAGES rising edges.
- Edge detect: one history flop per bit holds the previous synchronised value.
  - Rising edge: sync = 1 and prev = 0. Falling edge: sync = 0 and prev = 1.
  - A detected edge of the selected polarity sets IRQ_STATUS[n] on the next edge, only if IRQ_MASK[n] = 1.
  - Status bits are sticky until cleared.
- Simultaneous set and W1C clear on the same bit in the same cycle: set wins.
- Clearing a mask bit does not clear its status bit.
- o_irq = OR of IRQ_STATUS bits. Combinational from status flops; no extra latency.
- Reset asserted mid-transfer: the transfer is abandoned and no ack is issued. After reset release, the first accepted strobe behaves normally.
- OUT and DIR are independent: o_gpio keeps its value when oe = 0.

Optional Feature:
- Macro SUBSERVIENT_GPIO_IRQ_EN.
- Defined: edge detection, IRQ_MASK, IRQ_POL and IRQ_STATUS are implemented as above.
- Undefined: no history or IRQ flops are built. Addresses 3..5 behave as unmapped (read 0, writes ignored), and o_irq is tied to 0.
- Handshake and all other registers are identical in both builds.

Test Plan:
- Reset: hold i_wb_rst_n = 0 mid-transfer with stb = 1 -> ack = 0, o_gpio = 0, o_gpio_oe = 0, o_irq = 0. After release, write OUT = 0xA5 -> o_gpio = 0xA5 on the ack edge.
- Write DIR = 0x0F then read DIR -> each ack one cycle after stb; o_wb_rdt = 0x0000000F. Write 0xFFFFFFFF to OUT with WIDTH = 8, read back -> 0x000000FF.
- Drive i_gpio = 0x3C with SYNC_STAGES = 2 -> IN reads 0x00 if sampled before 2 edges, 0x3C after. Write 0xFF to IN -> IN is unchanged.
- IRQ_EN: MASK = 0x01, POL = 0, toggle i_gpio[0] 0→1 -> STATUS = 0x01 and o_irq = 1. Toggle i_gpio[1] (unmasked) -> STATUS unchanged. Write STATUS = 0x01 -> o_irq = 0.
- IRQ_EN: POL = 0x01 with falling edge on bit 0 coinciding with a W1C of bit 0 -> STATUS[0] remains 1.
- Continuous stb = 1 for 6 cycles reading IN -> ack pattern 0,1,0,1,0,1 with three transfers. Without the macro, reading address 5 -> 0 and o_irq stays 0.
